// File: rtl/invader_fleet_if.sv
// Bundle between the invader fleet controller and the rest of the game core:
// per-frame and collision inputs in, fleet geometry and bomb state out.
interface invader_fleet_if;
    logic       frame;
    logic [5:0] invader_collision;
    logic       bomb_hit;
    logic [9:0] fleet_x;
    logic [9:0] fleet_y;
    logic [5:0] invader_alive;
    logic [9:0] bomb_x;
    logic [9:0] bomb_y;
    logic       bomb_active;
    logic       fleet_landed;
    logic       wave_clear;

    modport master (
        output frame, invader_collision, bomb_hit,
        input  fleet_x, fleet_y, invader_alive, bomb_x, bomb_y,
               bomb_active, fleet_landed, wave_clear
    );

    modport slave (
        input  frame, invader_collision, bomb_hit,
        output fleet_x, fleet_y, invader_alive, bomb_x, bomb_y,
               bomb_active, fleet_landed, wave_clear
    );
endinterface

// File: rtl/invader_fleet.sv
// Six-invader fleet controller: alive mask, march/drop motion with speed-up,
// wave reload, landing detection and a single LFSR-targeted falling bomb.
module invader_fleet #(
    parameter int PITCH       = 48,
    parameter int INV_W       = 32,
    parameter int INV_H       = 24,
    parameter int START_X     = 64,
    parameter int START_Y     = 48,
    parameter int LEFT_BOUND  = 8,
    parameter int RIGHT_BOUND = 632,
    parameter int STEP_X      = 8,
    parameter int STEP_Y      = 16,
    parameter int LAND_Y      = 400,
    parameter int BOMB_PERIOD = 32,
    parameter int BOMB_SPEED  = 4,
    parameter int BOMB_H      = 8
) (
    input  logic           clk,
    input  logic           arst,
    invader_fleet_if.slave bus
);
    localparam int               TMR_W         = $clog2(BOMB_PERIOD);
    localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(BOMB_PERIOD - 1);
    localparam logic [9:0]       PITCH_W       = 10'(PITCH);
    localparam logic [9:0]       INV_W_W       = 10'(INV_W);
    localparam logic [9:0]       HALF_W        = 10'(INV_W / 2);
    localparam logic [9:0]       INV_H_W       = 10'(INV_H);
    localparam logic [9:0]       START_X_W     = 10'(START_X);
    localparam logic [9:0]       START_Y_W     = 10'(START_Y);
    localparam logic [9:0]       LEFT_BOUND_W  = 10'(LEFT_BOUND);
    localparam logic [9:0]       RIGHT_BOUND_W = 10'(RIGHT_BOUND);
    localparam logic [9:0]       STEP_X_W      = 10'(STEP_X);
    localparam logic [9:0]       STEP_Y_W      = 10'(STEP_Y);
    localparam logic [9:0]       LAND_Y_W      = 10'(LAND_Y);
    localparam logic [9:0]       BOMB_SPEED_W  = 10'(BOMB_SPEED);
    localparam logic [9:0]       RETIRE_Y      = 10'(480 - BOMB_H);

    typedef enum logic [1:0] {MARCH_R, MARCH_L, CLEARED, LANDED} state_t;

    state_t           state, state_nxt;
    logic [9:0]       fleet_x, fleet_x_nxt, fleet_y, fleet_y_nxt;
    logic [5:0]       alive, alive_nxt;
    logic [9:0]       bomb_x, bomb_x_nxt, bomb_y, bomb_y_nxt;
    logic             bomb_active, bomb_active_nxt;
    logic             landed, landed_nxt;
    logic             wave_clear, wave_clear_nxt;
    logic [3:0]       frame_cnt, frame_cnt_nxt;
    logic [TMR_W-1:0] bomb_tmr, bomb_tmr_nxt;
    logic             pending, pending_nxt;
    logic [7:0]       lfsr;

    logic [3:0] alive_cnt, interval;
    logic [2:0] lo_idx, hi_idx, col;
    logic [7:0] alive_ext;
    logic [9:0] lmost, rmost, drop_y, fall_y;
    logic [5:0] hit_alive;
    logic       move, at_edge, do_drop, attempt, col_ok;

    // Extents and interval come from the registered mask, so a same-cycle hit never affects a move.
    always_comb begin
        alive_cnt = '0;
        lo_idx    = '0;
        hi_idx    = '0;
        for (int i = 5; i >= 0; i--) begin
            if (alive[i]) lo_idx = 3'(i);
        end
        for (int i = 0; i < 6; i++) begin
            alive_cnt = alive_cnt + 4'(alive[i]);
            if (alive[i]) hi_idx = 3'(i);
        end
    end

    assign interval  = alive_cnt + 4'd2;
    assign lmost     = fleet_x + PITCH_W * {7'd0, lo_idx};
    assign rmost     = fleet_x + PITCH_W * {7'd0, hi_idx} + INV_W_W;
    assign move      = bus.frame && (frame_cnt >= interval - 4'd1);
    assign at_edge   = (state == MARCH_R) ? (rmost + STEP_X_W > RIGHT_BOUND_W)
                                          : (lmost < LEFT_BOUND_W + STEP_X_W);
    assign do_drop   = move && at_edge;
    assign drop_y    = fleet_y + STEP_Y_W;
    assign hit_alive = alive & ~bus.invader_collision;
    assign col       = lfsr[2:0];
    assign alive_ext = {2'b00, alive};
    assign col_ok    = alive_ext[col];
    assign attempt   = bus.frame && (pending || bomb_tmr == TMR_LAST);
    assign fall_y    = bomb_y + BOMB_SPEED_W;

    always_comb begin
        // NOTE: every target gets its default first, so no branch can infer a latch.
        state_nxt       = state;
        fleet_x_nxt     = fleet_x;
        fleet_y_nxt     = fleet_y;
        alive_nxt       = alive;
        bomb_x_nxt      = bomb_x;
        bomb_y_nxt      = bomb_y;
        bomb_active_nxt = bomb_active;
        landed_nxt      = landed;
        wave_clear_nxt  = 1'b0;
        frame_cnt_nxt   = frame_cnt;
        bomb_tmr_nxt    = bomb_tmr;
        pending_nxt     = pending;
        case (state)
            MARCH_R, MARCH_L: begin
                alive_nxt = hit_alive;
                if (hit_alive == '0) begin
                    state_nxt       = CLEARED;
                    wave_clear_nxt  = 1'b1;
                    bomb_active_nxt = 1'b0;
                    bomb_x_nxt      = '0;
                    bomb_y_nxt      = '0;
                end else begin
                    if (bus.frame) begin
                        frame_cnt_nxt = move ? 4'd0 : frame_cnt + 4'd1;
                        bomb_tmr_nxt  = (bomb_tmr == TMR_LAST) ? '0 : bomb_tmr + 1'b1;
                    end
                    if (do_drop) begin
                        fleet_y_nxt = drop_y;
                        if (drop_y + INV_H_W >= LAND_Y_W) begin
                            state_nxt  = LANDED;
                            landed_nxt = 1'b1;
                        end else begin
                            state_nxt = (state == MARCH_R) ? MARCH_L : MARCH_R;
                        end
                    end else if (move) begin
                        fleet_x_nxt = (state == MARCH_R) ? fleet_x + STEP_X_W : fleet_x - STEP_X_W;
                    end
                    if (bomb_active) begin
                        if (bus.bomb_hit) begin
                            bomb_active_nxt = 1'b0;
                        end else if (bus.frame) begin
                            bomb_y_nxt = fall_y;
                            if (fall_y >= RETIRE_Y) bomb_active_nxt = 1'b0;
                        end
                    end
                    // A launch needs an idle bomb at frame start; a failed try is retried next frame.
                    if (attempt) begin
                        if (!bomb_active && col_ok) begin
                            bomb_active_nxt = 1'b1;
                            bomb_x_nxt      = fleet_x + PITCH_W * {7'd0, col} + HALF_W;
                            bomb_y_nxt      = fleet_y + INV_H_W;
                            pending_nxt     = 1'b0;
                        end else begin
                            pending_nxt = 1'b1;
                        end
                    end
                end
            end
            CLEARED: begin
                if (bus.frame) begin
                    state_nxt     = MARCH_R;
                    fleet_x_nxt   = START_X_W;
                    fleet_y_nxt   = START_Y_W;
                    alive_nxt     = 6'b111111;
                    frame_cnt_nxt = '0;
                    bomb_tmr_nxt  = '0;
                    pending_nxt   = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!arst) begin
            state       <= MARCH_R;
            fleet_x     <= START_X_W;
            fleet_y     <= START_Y_W;
            alive       <= 6'b111111;
            bomb_x      <= '0;
            bomb_y      <= '0;
            bomb_active <= 1'b0;
            landed      <= 1'b0;
            wave_clear  <= 1'b0;
            frame_cnt   <= '0;
            bomb_tmr    <= '0;
            pending     <= 1'b0;
        end else begin
            state       <= state_nxt;
            fleet_x     <= fleet_x_nxt;
            fleet_y     <= fleet_y_nxt;
            alive       <= alive_nxt;
            bomb_x      <= bomb_x_nxt;
            bomb_y      <= bomb_y_nxt;
            bomb_active <= bomb_active_nxt;
            landed      <= landed_nxt;
            wave_clear  <= wave_clear_nxt;
            frame_cnt   <= frame_cnt_nxt;
            bomb_tmr    <= bomb_tmr_nxt;
            pending     <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) lfsr <= 8'hA5;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign bus.fleet_x       = fleet_x;
    assign bus.fleet_y       = fleet_y;
    assign bus.invader_alive = alive;
    assign bus.bomb_x        = bomb_x;
    assign bus.bomb_y        = bomb_y;
    assign bus.bomb_active   = bomb_active;
    assign bus.fleet_landed  = landed;
    assign bus.wave_clear    = wave_clear;
endmodule

// File: doc/invader_fleet.md
# invader_fleet

Invader fleet controller for the game core. It owns six invaders in one row: their alive mask, the fleet's march/drop motion, and a single falling bomb. It consumes the per-invader hit pulses from collision detection, which the laser and score stages also consume. It produces the fleet geometry and bomb position that feed collision detection and the renderer.

## Interface
- PITCH, 48, horizontal distance between invader origins (px)
- INV_W, 32, invader width (px)
- INV_H, 24, invader height (px)
- START_X, 64, fleet origin x after reset or wave reload
- START_Y, 48, fleet origin y after reset or wave reload
- LEFT_BOUND, 8, minimum allowed invader left edge
- RIGHT_BOUND, 632, maximum allowed invader right edge
- STEP_X, 8, horizontal march step (px)
- STEP_Y, 16, drop step (px)
- LAND_Y, 400, fleet bottom at or past this value means landed
- BOMB_PERIOD, 32, frames between bomb launch attempts
- BOMB_SPEED, 4, bomb fall per frame (px)
- BOMB_H, 8, bomb height; the bomb retires when bomb_y >= 480 - BOMB_H
- clk  input  1  system clock
- arst  input  1  reset, asynchronous, active-low
- frame  input  1  one-cycle pulse per video frame
- invader_collision  input  6  one-cycle hit pulse per invader; bit i = invader i
- bomb_hit  input  1  one-cycle pulse: bomb struck the player
- fleet_x, fleet_y  output  10  origin of invader 0; invader i is at x = fleet_x + i*PITCH
- invader_alive  output  6  alive mask
- bomb_x, bomb_y  output  10  bomb top-centre position
- bomb_active  output  1  bomb is in flight
- fleet_landed  output  1  fleet reached LAND_Y; sticky until reset
- wave_clear  output  1  one-cycle pulse when the last invader dies

## Operation
- States: MARCH_R, MARCH_L, CLEARED, LANDED. Reset state is MARCH_R.
- Hits: every cycle, invader_alive &= ~invader_collision. Hits on already-dead invaders are ignored.
- Motion:
  - Interval = popcount(invader_alive) + 2 frames: 8 with the full fleet, 3 with one invader left.
  - A frame counter advances on each frame pulse. When it reaches interval-1 it clears and a move occurs.
- Extents, computed from the registered alive mask:
  - lmost = fleet_x + idx_lowest_alive*PITCH
  - rmost = fleet_x + idx_highest_alive*PITCH + INV_W
- Move in MARCH_R:
  - If rmost + STEP_X > RIGHT_BOUND: fleet_y += STEP_Y and go to MARCH_L; x is unchanged.
  - Otherwise fleet_x += STEP_X.
- Move in MARCH_L:
  - If lmost < LEFT_BOUND + STEP_X: drop as above and go to MARCH_R.
  - Otherwise fleet_x -= STEP_X.
- Landing: after any drop, if new fleet_y + INV_H >= LAND_Y, go to LANDED and set fleet_landed. In LANDED, fleet, bomb and counters all freeze.
- Wave clear:
  - When alive goes to 0, assert wave_clear for one cycle and go to CLEARED. The bomb is cleared.
  - On the next frame pulse, reload: fleet_x = START_X, fleet_y = START_Y, alive = 6'b111111, counters = 0, state = MARCH_R.
- LFSR: 8-bit, taps 8,6,5,4, seed 8'hA5, advances every clk. col = lfsr[2:0]; values 6 and 7 give no launch.
- Bomb timer: counts frames; at BOMB_PERIOD-1 it attempts a launch and clears.
- Bomb launch:
  - Occurs only if bomb_active = 0, state is MARCH_*, and invader_alive[col] = 1.
  - Then bomb_active = 1, bomb_x = fleet_x + col*PITCH + INV_W/2, bomb_y = fleet_y + INV_H.
  - A failed attempt retries on every following frame until a launch succeeds.
- Bomb flight: each frame, bomb_y += BOMB_SPEED. The bomb retires (bomb_active = 0) when bomb_y >= 480 - BOMB_H, or on bomb_hit.
- Arithmetic is 10-bit unsigned. Parameters guarantee that no under- or overflow occurs.

## Timing
- All outputs are registered. A hit or frame event on cycle N is visible on cycle N+1.
- Reset values:
  - fleet_x = START_X, fleet_y = START_Y, invader_alive = 6'b111111
  - bomb_x = bomb_y = 0, bomb_active = 0
  - fleet_landed = 0, wave_clear = 0
  - all counters = 0, LFSR = 8'hA5
- A hit and a move on the same cycle:
  - The move uses the pre-hit mask for extents and interval.
  - The mask update lands on the same edge as the move.
- A hit on the last invader on the same cycle as a move: CLEARED wins and no move is applied.
- bomb_hit and retirement on the same cycle behave as a single retirement. bomb_hit while inactive is ignored.
- Launch and retirement never occur on the same frame; a launch needs bomb_active = 0 at the start of the frame.
- arst asserted mid-operation: all state returns to reset values immediately, with no frame dependency.

## Test plan
- March: reset, then 8 frames → fleet_x = 72. Continue to 37 moves → fleet_x = 360. The 38th move → fleet_x = 360, fleet_y = 64, state MARCH_L.
- Kill and speed-up: pulse invader_collision = 6'b100000 → invader_alive = 6'b011111 next cycle; interval is now 7. rmost drops by 48, so the right-edge drop happens later.
- Clear wave: hit all six invaders (mixed single and simultaneous pulses) → one-cycle wave_clear and bomb_active = 0. The next frame reloads to 64/48 with alive = 6'b111111.
- Landing: march to the 21st drop (fleet_y = 384, bottom 408 >= 400) → fleet_landed = 1. Further frames leave fleet_x, fleet_y and bomb unchanged.
- Bomb: force col = 2 with invader 2 alive at the launch frame → bomb_x = fleet_x + 112, bomb_y = fleet_y + 24. bomb_y rises by 4 per frame; bomb_hit → bomb_active = 0 next cycle. With no hit, the bomb retires when bomb_y >= 472.
- Reset mid-drop: assert arst while in MARCH_L with invaders killed → every output returns to its reset value before the next clk edge.
